pc_npc_sequencer: RTL and testbench
===================================

// Module: pc_npc_sequencer
// PURPOSE
//  Front-end controller owning the PC/nPC pair for the SPARC-style pipeline. Each cycle it picks the next
//  nPC (nPC+4, branch/call target TA, or JMPL ALU result) and implements delayed-CTI semantics.
//  It also applies the annul bit (delay-slot squash) and stalls, and drives fetch enable to instruction memory.
//  It sits between the ID-stage decode/condition logic and the IF stage.
// PARAMETERS
//  ADDR_W     32  width of PC/nPC/TA/ALU_OUT
//  RESET_PC   0   PC value loaded by clr
//  RESET_NPC  4   nPC value loaded by clr
// PORTS
//  clk           in   1       clock, rising edge
//  clr           in   1       reset; asynchronous, active-high
//  stall         in   1       hazard hold; freezes PC, nPC, state and annul flag
//  cti_valid     in   1       ID holds a control-transfer instr (branch/call/jmpl) this cycle
//  ID_call_instr in   1       CTI is CALL
//  ID_jmpl_instr in   1       CTI is JMPL
//  branch_out    in   1       condition evaluated true (branch taken)
//  ID_is_ba      in   1       branch is unconditional BA (condition always true)
//  ID_annul      in   1       annul bit (a) of the branch
//  TA            in   ADDR_W  branch/call target
//  ALU_OUT       in   ADDR_W  JMPL target
//  pc            out  ADDR_W  current fetch address
//  npc           out  ADDR_W  next fetch address
//  fetch_en      out  1       instruction-memory read enable
//  if_flush      out  1       squash instr entering IF/ID this cycle (annulled delay slot)
//  misalign_err  out  1       sticky target-misalignment flag (ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  - clr: pc=RESET_PC, npc=RESET_NPC, state=S_BOOT, annul flag=0, if_flush=0, fetch_en=0, misalign_err=0.
//  - States: S_BOOT -> S_RUN after 1 cycle (fetch_en=0 in S_BOOT, 1 in S_RUN). S_HALT is terminal until clr.
//  - S_RUN, !stall: pc<=npc; npc<=next_npc. Select priority, all gated by cti_valid:
//    jmpl -> ALU_OUT; call -> TA; branch && (branch_out|ID_is_ba) -> TA; else npc+4.
//  - Delayed CTI: target is seen on pc 2 cycles after the CTI is in ID. The delay slot instr (old npc) is always fetched.
//  - Annul: set flag when cti_valid, the instr is a branch, ID_annul=1, and (not taken OR ID_is_ba).
//    Next advancing cycle: if_flush=1 for exactly 1 cycle; delay-slot instr is squashed; flag clears.
//    Call/jmpl ignore ID_annul.
//  - stall=1: all registers hold, if_flush held 0, fetch_en stays 1. CTI inputs are ignored; ID re-presents them.
//    Pending annul survives the stall and fires on the first non-stalled cycle.
//  - Arithmetic: npc+4 is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0, no flag.
//  - Multiple CTI flags asserted together: priority above applies; no error.
//  - clr mid-operation discards a pending annul and any redirect.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: a selected TA/ALU_OUT with [1:0]!=0 sets misalign_err.
//    In that cycle pc/npc do not update, and the block enters S_HALT (fetch_en=0).
//  ALIGN_CHECK_EN undefined: no check; target used as-is; misalign_err constant 0; S_HALT unreachable.
// STRUCTURE
//  - pc_seq_pkg holds:
//    - state enum S_BOOT/S_RUN/S_HALT
//    - NPC_SEL codes: SEL_INC=2'b00, SEL_TA=2'b01, SEL_ALU=2'b10
//    - INSTR_BYTES=4
//  - Sub-module pc_next_sel (combinational): CTI flags -> NPC_SEL code plus annul request.
//    The top level holds the FSM, PC/nPC flops and annul flag.
// TESTING
//  - clr pulse, release -> pc=0,npc=4,fetch_en=0 for 1 cycle; then pc=0,4,8,12 on successive edges.
//  - Taken branch at pc=0x10, TA=0x100, a=0 -> pc seq 0x10,0x14,0x100,0x104; if_flush never 1.
//  - Untaken branch a=1 at 0x20 -> if_flush=1 in the cycle 0x24 advances; pc seq 0x20,0x24,0x28.
//  - BA a=1 at 0x30, TA=0x200 -> delay slot 0x34 flushed; pc 0x200 next; call with a=1 at 0x40 -> no flush.
//  - JMPL ALU_OUT=0x400 and call TA=0x500 together -> npc=0x400.
//    stall 3 cycles during pending annul -> pc frozen; flush fires after stall.
//  - ALIGN_CHECK_EN: JMPL ALU_OUT=0x402 -> misalign_err=1, fetch_en=0, pc frozen; clr recovers to pc=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC/nPC sequencer
//
// Purpose : state encoding, nPC source select codes and instruction size
//           used by pc_npc_sequencer and pc_next_sel.
// Ports   : none (package).
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SEL_INC = 2'b00,
    SEL_TA  = 2'b01,
    SEL_ALU = 2'b10
  } npc_sel_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational nPC source select and annul request
//
// Purpose : decodes the ID-stage CTI flags into an nPC select code and a
//           request to squash the delay-slot instruction.
// Ports   : cti_valid, call_instr, jmpl_instr, branch_out, is_ba, annul (in)
//           npc_sel [1:0] (out)  SEL_INC / SEL_TA / SEL_ALU
//           annul_req     (out)  set the annul flag on the next advance
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic       cti_valid,
  input  logic       call_instr,
  input  logic       jmpl_instr,
  input  logic       branch_out,
  input  logic       is_ba,
  input  logic       annul,
  output logic [1:0] npc_sel,
  output logic       annul_req
);

  // Priority: jmpl over call over branch. Only plain branches honour the
  // annul bit; a taken conditional branch keeps its delay slot, while BA
  // with a=1 always squashes it.
  always_comb begin
    npc_sel   = SEL_INC;
    annul_req = 1'b0;
    if (cti_valid) begin
      if (jmpl_instr) begin
        npc_sel = SEL_ALU;
      end else if (call_instr) begin
        npc_sel = SEL_TA;
      end else begin
        if (branch_out | is_ba) begin
          npc_sel = SEL_TA;
        end
        annul_req = annul & (~branch_out | is_ba);
      end
    end
  end

endmodule

// File: rtl/pc_npc_sequencer.sv
// rtl/pc_npc_sequencer.sv - PC/nPC pair with delayed-CTI, annul and stall handling
//
// Purpose : owns PC/nPC for the fetch front end. Every advancing cycle
//           pc <= npc and npc <= nPC+4 / TA / ALU_OUT, so a CTI in ID reaches
//           pc two edges later and its delay slot is always fetched. A
//           pending annul raises if_flush for one advancing cycle.
// Option  : ALIGN_CHECK_EN - a selected TA/ALU_OUT target with nonzero [1:0]
//           sets the sticky misalign_err, freezes pc/npc and halts fetch.
// Ports   : clk, clr (async, active-high), stall,
//           cti_valid, ID_call_instr, ID_jmpl_instr, branch_out, ID_is_ba,
//           ID_annul, TA, ALU_OUT (in);
//           pc, npc, fetch_en, if_flush, misalign_err (out)
module pc_npc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] RESET_NPC = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              stall,
  input  logic              cti_valid,
  input  logic              ID_call_instr,
  input  logic              ID_jmpl_instr,
  input  logic              branch_out,
  input  logic              ID_is_ba,
  input  logic              ID_annul,
  input  logic [ADDR_W-1:0] TA,
  input  logic [ADDR_W-1:0] ALU_OUT,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              fetch_en,
  output logic              if_flush,
  output logic              misalign_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic              annul_q, annul_d;
  logic [1:0]        npc_sel;
  logic              annul_req;
  logic [ADDR_W-1:0] npc_inc;
  logic [ADDR_W-1:0] npc_next;
  logic              target_bad;
  logic              halt_enter;

  pc_next_sel u_next_sel (
    .cti_valid  (cti_valid),
    .call_instr (ID_call_instr),
    .jmpl_instr (ID_jmpl_instr),
    .branch_out (branch_out),
    .is_ba      (ID_is_ba),
    .annul      (ID_annul),
    .npc_sel    (npc_sel),
    .annul_req  (annul_req)
  );

  // Modulo 2^ADDR_W; wrap past the top of the address space is silent.
  assign npc_inc = npc_q + ADDR_W'(INSTR_BYTES);

  always_comb begin
    npc_next = npc_inc;
    case (npc_sel)
      SEL_TA:  npc_next = TA;
      SEL_ALU: npc_next = ALU_OUT;
      default: npc_next = npc_inc;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  logic misalign_q;

  assign target_bad = (npc_sel != SEL_INC) && (npc_next[1:0] != 2'b00);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      misalign_q <= 1'b0;
    end else if (halt_enter) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign target_bad   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Stall freezes everything including the annul flag, so a pending squash
  // lands on the first cycle that actually advances.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    annul_d    = annul_q;
    fetch_en   = 1'b0;
    if_flush   = 1'b0;
    halt_enter = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        fetch_en = 1'b1;
        if (!stall) begin
          if (target_bad) begin
            state_d    = S_HALT;
            halt_enter = 1'b1;
          end else begin
            if_flush = annul_q;
            pc_d     = npc_q;
            npc_d    = npc_next;
            annul_d  = annul_req;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_NPC;
      annul_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      annul_q <= annul_d;
    end
  end

  assign pc  = pc_q;
  assign npc = npc_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// tb/tb_pc_npc_sequencer.sv - directed table-driven bench for pc_npc_sequencer
module tb_pc_npc_sequencer;
  import pc_seq_pkg::*;

  logic        clk;
  logic        clr;
  logic        stall;
  logic        cti_valid;
  logic        ID_call_instr;
  logic        ID_jmpl_instr;
  logic        branch_out;
  logic        ID_is_ba;
  logic        ID_annul;
  logic [31:0] TA;
  logic [31:0] ALU_OUT;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        fetch_en;
  logic        if_flush;
  logic        misalign_err;

  pc_npc_sequencer #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0),
    .RESET_NPC (32'h4)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .stall         (stall),
    .cti_valid     (cti_valid),
    .ID_call_instr (ID_call_instr),
    .ID_jmpl_instr (ID_jmpl_instr),
    .branch_out    (branch_out),
    .ID_is_ba      (ID_is_ba),
    .ID_annul      (ID_annul),
    .TA            (TA),
    .ALU_OUT       (ALU_OUT),
    .pc            (pc),
    .npc           (npc),
    .fetch_en      (fetch_en),
    .if_flush      (if_flush),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st, cv, ca, jm, bo, ba, an;
    logic [31:0] ta, alu;
    logic [31:0] epc, enpc;
    logic        efe, efl;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic st, cv, ca, jm, bo, ba, an,
                     input logic [31:0] ta, alu, epc, enpc,
                     input logic efe, efl);
    vec_t v;
    v.st = st; v.cv = cv; v.ca = ca; v.jm = jm; v.bo = bo; v.ba = ba; v.an = an;
    v.ta = ta; v.alu = alu; v.epc = epc; v.enpc = enpc; v.efe = efe; v.efl = efl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, cv, ca, jm, bo, ba, an,
                       input logic [31:0] ta, alu);
    stall = st; cti_valid = cv; ID_call_instr = ca; ID_jmpl_instr = jm;
    branch_out = bo; ID_is_ba = ba; ID_annul = an; TA = ta; ALU_OUT = alu;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    //   st cv ca jm bo ba an  TA            ALU           pc            npc           fe fl
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        0, 0); // boot
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        32'h8,        1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        32'hC,        1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hC,        32'h10,       1, 0);
    add(0, 1, 0, 0, 1, 0, 0, 32'h100,      32'h0,        32'h10,       32'h14,       1, 0); // taken br a=0
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h14,       32'h100,      1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      32'h104,      1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h20,       32'h104,      32'h108,      1, 0); // jmpl 0x20
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h108,      32'h20,       1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 32'h700,      32'h0,        32'h20,       32'h24,       1, 0); // untaken a=1
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h24,       32'h28,       1, 1); // squash
    add(0, 1, 0, 0, 1, 0, 1, 32'h30,       32'h0,        32'h28,       32'h2C,       1, 0); // taken a=1
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2C,       32'h30,       1, 0);
    add(0, 1, 0, 0, 0, 1, 1, 32'h200,      32'h0,        32'h30,       32'h34,       1, 0); // BA a=1
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h34,       32'h200,      1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h200,      32'h204,      1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 32'h40,       32'h0,        32'h204,      32'h208,      1, 0); // call a=1
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h208,      32'h40,       1, 0);
    add(0, 1, 1, 1, 0, 0, 1, 32'h500,      32'h400,      32'h40,       32'h44,       1, 0); // jmpl+call
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h44,       32'h400,      1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 32'h800,      32'h0,        32'h400,      32'h404,      1, 0); // untaken a=1
    add(1, 1, 0, 0, 1, 0, 0, 32'h900,      32'h0,        32'h404,      32'h408,      1, 0); // stall x3
    add(1, 1, 0, 0, 1, 0, 0, 32'h900,      32'h0,        32'h404,      32'h408,      1, 0);
    add(1, 1, 0, 0, 1, 0, 0, 32'h900,      32'h0,        32'h404,      32'h408,      1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h404,      32'h408,      1, 1); // flush after
    add(0, 1, 0, 0, 0, 0, 0, 32'hA00,      32'h0,        32'h408,      32'h40C,      1, 0); // untaken a=0
    add(0, 1, 0, 1, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 32'h40C,      32'h410,      1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h410,      32'hFFFFFFFC, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        1, 0); // wrap
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h402,      32'h4,        32'h8,        1, 0); // jmpl 0x402

    idle();
    clr = 1'b1;
    #12;
    chk("reset_pc", pc, 32'h0);
    chk("reset_npc", npc, 32'h4);
    chk("reset_fetch_en", {31'b0, fetch_en}, 32'h0);
    chk("reset_if_flush", {31'b0, if_flush}, 32'h0);
    chk("reset_misalign", {31'b0, misalign_err}, 32'h0);

    @(negedge clk);
    clr = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].cv, vecs[i].ca, vecs[i].jm, vecs[i].bo,
            vecs[i].ba, vecs[i].an, vecs[i].ta, vecs[i].alu);
      #1;
      chk($sformatf("row%0d_pc", i), pc, vecs[i].epc);
      chk($sformatf("row%0d_npc", i), npc, vecs[i].enpc);
      chk($sformatf("row%0d_fetch_en", i), {31'b0, fetch_en}, {31'b0, vecs[i].efe});
      chk($sformatf("row%0d_if_flush", i), {31'b0, if_flush}, {31'b0, vecs[i].efl});
      chk($sformatf("row%0d_misalign", i), {31'b0, misalign_err}, 32'h0);
      @(negedge clk);
    end

    idle();
    #1;
`ifdef ALIGN_CHECK_EN
    chk("align_pc_frozen", pc, 32'h4);
    chk("align_npc_frozen", npc, 32'h8);
    chk("align_err_set", {31'b0, misalign_err}, 32'h1);
    chk("align_fetch_off", {31'b0, fetch_en}, 32'h0);
    @(negedge clk);
    #1;
    chk("halt_pc_held", pc, 32'h4);
    chk("halt_err_sticky", {31'b0, misalign_err}, 32'h1);
    chk("halt_fetch_off", {31'b0, fetch_en}, 32'h0);
`else
    chk("noalign_pc", pc, 32'h8);
    chk("noalign_npc", npc, 32'h402);
    chk("noalign_err", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    #1;
    chk("noalign_pc2", pc, 32'h402);
    chk("noalign_npc2", npc, 32'h406);
`endif

    // clr recovers, then clr during a pending annul discards it
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_pc", pc, 32'h0);
    chk("clr_npc", npc, 32'h4);
    chk("clr_misalign", {31'b0, misalign_err}, 32'h0);
    chk("clr_fetch_en", {31'b0, fetch_en}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("reboot_fetch_en", {31'b0, fetch_en}, 32'h0);
    @(negedge clk);
    #1;
    chk("rerun_pc", pc, 32'h0);
    chk("rerun_fetch_en", {31'b0, fetch_en}, 32'h1);
    drive(0, 1, 0, 0, 0, 0, 1, 32'h600, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("pend_pc", pc, 32'h4);
    chk("pend_flush", {31'b0, if_flush}, 32'h1);
    clr = 1'b1;
    #1;
    chk("clr_pend_flush", {31'b0, if_flush}, 32'h0);
    chk("clr_pend_pc", pc, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    #1;
    chk("post_clr_pc", pc, 32'h0);
    chk("post_clr_flush", {31'b0, if_flush}, 32'h0);
    @(negedge clk);
    #1;
    chk("post_clr_pc2", pc, 32'h4);
    chk("post_clr_flush2", {31'b0, if_flush}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
